// File: rtl/reg_alu_pkg.sv
// Shared types for the register-file/ALU datapath: opcodes, flag bit positions, FSM states.
package reg_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_SLT   = 3'b101,
    OP_MUL   = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/reg_alu_seq_if.sv
// Issue handshake and result bus between the sequencer (master) and reg_alu_seq (slave).
interface reg_alu_seq_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic             valid;
  logic             ready;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] ext_data;
  logic             alu_src;
  logic [2:0]       alu_op;
  logic             reg_write;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [3:0]       flags;

  modport master (
    output valid, ra1, ra2, wa, ext_data, alu_src, alu_op, reg_write,
    input  ready, result, result_valid, flags
  );

  modport slave (
    input  valid, ra1, ra2, wa, ext_data, alu_src, alu_op, reg_write,
    output ready, result, result_valid, flags
  );
endinterface

// File: rtl/reg_alu_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
module reg_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  // The final step's sum is exposed combinationally so the caller can register it on the same edge.
  assign done    = (cnt_q == CW'(1));
  assign product = acc_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    acc_q    <= acc_d;
    mplier_q <= mplier_d;
  end

endmodule

// File: rtl/reg_alu_seq.sv
// Register file feeding a single-cycle ALU with write-back, registered result/NZCV flags and iterative MUL.
module reg_alu_seq
  import reg_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 16
) (
  input logic         clk,
  input logic         reset,
  reg_alu_seq_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res, input logic c,
                                            input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = res[WIDTH-1];
    f[FLAG_Z] = (res == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   regs_d [NREGS];
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               rv_q, rv_d;
  logic [AW-1:0]      wa_q, wa_d;
  logic               rw_q, rw_d;

  logic               ready;
  logic               accept;
  alu_op_t            op;
  logic [WIDTH-1:0]   opa, opb, opb_reg;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic               mul_start, mul_done, mul_hi;
  logic [2*WIDTH-1:0] mul_prod;
  logic               complete;
  logic [WIDTH-1:0]   cmp_res;
  logic [3:0]         cmp_flags;
  logic [AW-1:0]      cmp_wa;
  logic               cmp_rw;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_BUSY;
      ST_BUSY: if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: reset overrides so nothing is accepted while it is held
  always_comb begin
    ready = (state_q == ST_IDLE) && !reset;
  end

  assign accept    = bus.valid && ready;
  assign op        = alu_op_t'(bus.alu_op);
  assign mul_start = accept && (op == OP_MUL);

  // Register 0 is hardwired to zero on the read side; writes to it are filtered below.
  assign opa     = (bus.ra1 == '0) ? '0 : regs_q[bus.ra1];
  assign opb_reg = (bus.ra2 == '0) ? '0 : regs_q[bus.ra2];
  assign opb     = bus.alu_src ? bus.ext_data : opb_reg;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, opa} + {1'b0, opb};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, opa} + {1'b0, ~opb} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND:   alu_res = opa & opb;
      OP_OR:    alu_res = opa | opb;
      OP_XOR:   alu_res = opa ^ opb;
      OP_SLT:   alu_res = ($signed(opa) < $signed(opb)) ? WIDTH'(1) : '0;
      OP_PASSB: alu_res = opb;
      default:  alu_res = '0;
    endcase
  end

  reg_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mul_hi = |mul_prod[2*WIDTH-1:WIDTH];

  // Completion: either a single-cycle op at accept, or the last multiply step
  always_comb begin
    complete  = accept && (op != OP_MUL);
    cmp_res   = alu_res;
    cmp_flags = pack_flags(alu_res, alu_c, alu_v);
    cmp_wa    = bus.wa;
    cmp_rw    = bus.reg_write;
    if (state_q == ST_BUSY) begin
      complete  = mul_done;
      cmp_res   = mul_prod[WIDTH-1:0];
      cmp_flags = pack_flags(mul_prod[WIDTH-1:0], mul_hi, mul_hi);
      cmp_wa    = wa_q;
      cmp_rw    = rw_q;
    end

    wa_d = mul_start ? bus.wa        : wa_q;
    rw_d = mul_start ? bus.reg_write : rw_q;

    regs_d = regs_q;
    if (complete && cmp_rw && (cmp_wa != '0)) regs_d[cmp_wa] = cmp_res;

    result_d = complete ? cmp_res   : result_q;
    flags_d  = complete ? cmp_flags : flags_q;
    rv_d     = complete;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      result_q <= '0;
      flags_q  <= '0;
      rv_q     <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      rv_q     <= rv_d;
    end
  end

  always_ff @(posedge clk) begin
    wa_q <= wa_d;
    rw_q <= rw_d;
  end

  assign bus.ready        = ready;
  assign bus.result       = result_q;
  assign bus.flags        = flags_q;
  assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_reg_alu_seq.sv
// Directed vector bench for reg_alu_seq (WIDTH=8, NREGS=16): table of ops plus MUL busy/reset sequences.
module tb_reg_alu_seq;

  localparam int WIDTH = 8;
  localparam int NREGS = 16;

  typedef struct {
    logic [2:0] op;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa;
    logic [7:0] ext;
    logic       src;
    logic       rw;
    logic [7:0] exp_res;
    logic [3:0] exp_flg;
    int         lat;
  } vec_t;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SLT = 3'b101, MUL = 3'b110, PASSB = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  vec_t vecs[$];

  reg_alu_seq_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

  reg_alu_seq #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] ra1, input logic [3:0] ra2,
                              input logic [3:0] wa, input logic [7:0] ext, input logic src,
                              input logic rw, input logic [7:0] r, input logic [3:0] f);
    vec_t v;
    v.op = op; v.ra1 = ra1; v.ra2 = ra2; v.wa = wa; v.ext = ext; v.src = src; v.rw = rw;
    v.exp_res = r; v.exp_flg = f;
    v.lat = (op == MUL) ? 9 : 1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.alu_op    = v.op;
    bus.ra1       = v.ra1;
    bus.ra2       = v.ra2;
    bus.wa        = v.wa;
    bus.ext_data  = v.ext;
    bus.alu_src   = v.src;
    bus.reg_write = v.rw;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int lat;
    @(negedge clk);
    drive(v);
    bus.valid = 1'b1;
    n = 0;
    while (!bus.ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      bus.valid = 1'b0;
      chk({tag, "_accept_timeout"}, 32'(bus.ready), 32'd1);
      return;
    end
    @(posedge clk);
    #1 bus.valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.result_valid && lat < 30);
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    chk({tag, "_result"}, 32'(bus.result), 32'(v.exp_res));
    chk({tag, "_flags"}, 32'(bus.flags), 32'(v.exp_flg));
    @(negedge clk);
    chk({tag, "_rv_pulse"}, 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    int   busy;
    logic rv_seen;
    vec_t idle_v;

    // flags column is {N,Z,C,V}
    vecs.push_back(mk(ADD,   1, 2,  0, 8'h00, 0, 0, 8'h00, 4'b0100));
    vecs.push_back(mk(PASSB, 0, 0,  1, 8'h7F, 1, 1, 8'h7F, 4'b0000));
    vecs.push_back(mk(ADD,   1, 0,  2, 8'h01, 1, 1, 8'h80, 4'b1001));
    vecs.push_back(mk(OR_,   2, 0,  0, 8'h00, 0, 0, 8'h80, 4'b1000));
    vecs.push_back(mk(PASSB, 0, 0,  1, 8'h05, 1, 1, 8'h05, 4'b0000));
    vecs.push_back(mk(SUB,   1, 0,  0, 8'h05, 1, 0, 8'h00, 4'b0110));
    vecs.push_back(mk(PASSB, 0, 0,  4, 8'h03, 1, 1, 8'h03, 4'b0000));
    vecs.push_back(mk(SUB,   4, 0,  0, 8'h05, 1, 0, 8'hFE, 4'b1000));
    vecs.push_back(mk(PASSB, 0, 0,  5, 8'h80, 1, 1, 8'h80, 4'b1000));
    vecs.push_back(mk(SLT,   5, 0,  0, 8'h01, 1, 0, 8'h01, 4'b0000));
    vecs.push_back(mk(PASSB, 0, 0,  6, 8'hF0, 1, 1, 8'hF0, 4'b1000));
    vecs.push_back(mk(AND_,  6, 0,  0, 8'h3C, 1, 0, 8'h30, 4'b0000));
    vecs.push_back(mk(XOR_,  6, 0,  0, 8'hF0, 1, 0, 8'h00, 4'b0100));
    vecs.push_back(mk(PASSB, 0, 0,  7, 8'h10, 1, 1, 8'h10, 4'b0000));
    vecs.push_back(mk(MUL,   7, 0,  3, 8'h10, 1, 1, 8'h00, 4'b0111));
    vecs.push_back(mk(OR_,   3, 0,  0, 8'h00, 0, 0, 8'h00, 4'b0100));
    vecs.push_back(mk(PASSB, 0, 0,  8, 8'h07, 1, 1, 8'h07, 4'b0000));
    vecs.push_back(mk(MUL,   8, 0,  9, 8'h06, 1, 1, 8'h2A, 4'b0000));
    vecs.push_back(mk(OR_,   9, 0,  0, 8'h00, 0, 0, 8'h2A, 4'b0000));
    vecs.push_back(mk(PASSB, 0, 0,  0, 8'h55, 1, 1, 8'h55, 4'b0000));
    vecs.push_back(mk(OR_,   0, 0,  0, 8'h00, 0, 0, 8'h00, 4'b0100));
    vecs.push_back(mk(PASSB, 0, 0, 10, 8'hFF, 1, 1, 8'hFF, 4'b1000));
    vecs.push_back(mk(ADD,  10, 0,  0, 8'h01, 1, 0, 8'h00, 4'b0110));
    vecs.push_back(mk(SUB,   5, 0,  0, 8'h01, 1, 0, 8'h7F, 4'b0011));
    vecs.push_back(mk(PASSB, 0, 0, 11, 8'h01, 1, 1, 8'h01, 4'b0000));
    vecs.push_back(mk(SLT,  11, 5,  0, 8'h00, 0, 0, 8'h00, 4'b0100));
    vecs.push_back(mk(MUL,  10, 0,  0, 8'hFF, 1, 0, 8'h01, 4'b0011));

    idle_v = mk(ADD, 0, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0000);
    drive(idle_v);
    bus.valid = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    bus.valid = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(bus.ready), 32'd0);
    chk("reset_rv", 32'(bus.result_valid), 32'd0);
    chk("reset_result", 32'(bus.result), 32'd0);
    chk("reset_flags", 32'(bus.flags), 32'd0);
    bus.valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    chk("release_ready", 32'(bus.ready), 32'd1);
    chk("release_rv", 32'(bus.result_valid), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // MUL with valid held during BUSY: the held op must be ignored
    @(negedge clk);
    drive(mk(MUL, 8, 0, 12, 8'h06, 1, 1, 8'h00, 4'b0000));
    bus.valid = 1'b1;
    chk("seqA_ready_idle", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1 drive(mk(PASSB, 0, 0, 13, 8'hAA, 1, 1, 8'h00, 4'b0000));
    bus.valid = 1'b1;
    busy = 0;
    @(negedge clk);
    while (!bus.ready && busy < 30) begin
      busy++;
      @(negedge clk);
    end
    bus.valid = 1'b0;
    chk("seqA_busy_cycles", 32'(busy), 32'd8);
    chk("seqA_rv", 32'(bus.result_valid), 32'd1);
    chk("seqA_result", 32'(bus.result), 32'h2A);
    run_vec(mk(OR_, 13, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0100), "seqA_r13");
    run_vec(mk(OR_, 12, 0, 0, 8'h00, 0, 0, 8'h2A, 4'b0000), "seqA_r12");

    // Reset in the third BUSY cycle aborts the multiply
    run_vec(mk(PASSB, 0, 0, 14, 8'h11, 1, 1, 8'h11, 4'b0000), "seqB_set_r14");
    @(negedge clk);
    drive(mk(MUL, 8, 0, 14, 8'h06, 1, 1, 8'h00, 4'b0000));
    bus.valid = 1'b1;
    @(posedge clk);
    #1 bus.valid = 1'b0;
    rv_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      rv_seen |= bus.result_valid;
    end
    @(negedge clk);
    rv_seen |= bus.result_valid;
    reset     = 1'b1;
    bus.valid = 1'b1;
    #1 chk("seqB_ready_in_reset", 32'(bus.ready), 32'd0);
    repeat (2) begin
      @(negedge clk);
      rv_seen |= bus.result_valid;
    end
    reset     = 1'b0;
    bus.valid = 1'b0;
    @(negedge clk);
    chk("seqB_ready_after_release", 32'(bus.ready), 32'd1);
    rv_seen |= bus.result_valid;
    repeat (12) begin
      @(negedge clk);
      rv_seen |= bus.result_valid;
    end
    chk("seqB_no_rv_pulse", 32'(rv_seen), 32'd0);
    run_vec(mk(OR_, 14, 0, 0, 8'h00, 0, 0, 8'h00, 4'b0100), "seqB_r14");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/reg_alu_seq.md
# reg_alu_seq

Parametrised register-file/ALU datapath: the next generation of the team's 8-bit register file feeding an ALU with write-back. Adds configurable width and depth, a valid/ready issue handshake, a registered result and NZCV flags, and an iterative multi-cycle multiply. It sits between the instruction sequencer, which issues one operation per handshake, and any consumer of `result`/`flags`.

## Interface
- `WIDTH`, 8: datapath width in bits; must be at least 2.
- `NREGS`, 16: number of registers; must be a power of 2, at least 2. `AW = $clog2(NREGS)`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `valid` in 1: operation presented this cycle.
- `ready` out 1: block can accept an operation.
- `ra1`, `ra2` in AW: read addresses; source A is always reg[`ra1`].
- `wa` in AW: write-back address.
- `ext_data` in WIDTH: external operand.
- `alu_src` in 1: 0 → B = reg[`ra2`]; 1 → B = `ext_data`.
- `alu_op` in 3: operation code (see Operation).
- `reg_write` in 1: write result to reg[`wa`].
- `result` out WIDTH: registered result of the last completed operation.
- `result_valid` out 1: one-cycle pulse when `result`/`flags` update.
- `flags` out 4: registered {N, Z, C, V}.

## Operation
- Accept occurs when `valid && ready` is sampled at a rising edge. All operands and controls are captured at that edge. `valid` while `ready` = 0 is ignored (not queued), so the issuer holds its operation until accepted.
- Register 0 always reads 0; writes to it are dropped, but `result`/`flags` still update.
- Ops:
  - 000 ADD, 001 SUB (A − B), 010 AND, 011 OR, 100 XOR.
  - 101 SLT: signed A < B gives 1, else 0.
  - 110 MUL: low WIDTH bits of the product, multi-cycle.
  - 111 PASSB: result = B.
- Flags:
  - Z: result == 0. N: result[WIDTH-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: computed as A + ~B + 1; C = carry out (1 means no borrow); V = signed overflow.
  - MUL: C = V = (upper WIDTH bits of the 2·WIDTH product are non-zero).
  - All other ops: C = V = 0.
- FSM:
  - IDLE: `ready` = 1. A non-MUL accept completes at that same edge. A MUL accept latches the operands, clears the 2·WIDTH accumulator, loads the count with WIDTH and goes to BUSY.
  - BUSY: `ready` = 0. Each cycle performs one shift-add step and decrements the count. On the edge where the count reaches 0 the block completes and returns to IDLE.
- Completion, all at one edge:
  - `result` and `flags` registered.
  - reg[`wa`] written if `reg_write` (the values captured at accept) and `wa` ≠ 0.
  - `result_valid` is 1 for the following cycle only.
- No bypass is needed: a register written at edge k is visible to an operation accepted at edge k+1 or later.

## Timing
- Reset: all registers, `result`, `flags` = 0; `result_valid` = 0; FSM in IDLE. `ready` is 0 while `reset` = 1 and 1 in the first cycle after release.
- Non-MUL op accepted at edge k: `result_valid` is high in the cycle after k; a new op may be accepted at edge k+1 (throughput 1/cycle).
- MUL accepted at edge k:
  - `ready` = 0 from after edge k through edge k+WIDTH.
  - Completion at edge k+WIDTH; `result_valid` high in the cycle after it.
  - `ready` = 1 again in that same cycle, so the next accept can occur at edge k+WIDTH+1.
- Reset during BUSY aborts the multiply: no write-back and no `result_valid` pulse.
- If `reset` and `valid` are high together, reset wins and nothing is accepted.

## Structure
- Package `reg_alu_pkg`: `alu_op_t` enum (ADD…PASSB), flag bit index constants (N=3, Z=2, C=1, V=0), FSM state enum.
- Sub-module `reg_alu_mul`: iterative shift-add multiplier with start/done, producing the 2·WIDTH product. The register file and single-cycle ALU stay inline.

## Test plan
- Reset, then ADD with `ra1`=1, `ra2`=2, `alu_src`=0 → `result` 0x00, flags Z=1, `result_valid` one cycle.
- PASSB `ext_data`=0x7F into r1, then ADD r1 + ext 0x01 into r2 → 0x80, N=1, V=1, C=0, Z=0; reading r2 afterwards gives 0x80.
- SUB r1(0x05) − ext 0x05 → 0x00, Z=1, C=1. SUB 0x03 − 0x05 → 0xFE, N=1, C=0. SLT 0x80 vs 0x01 → 0x01.
- MUL 0x10 × 0x10 (WIDTH=8) into r3 → `result` 0x00, C=V=1. `ready` is low for exactly 8 cycles; `valid` pulses during BUSY are ignored. A following MUL 0x07 × 0x06 → 0x2A, C=V=0.
- PASSB 0x55 with `wa`=0 → `result` 0x55 but r0 still reads 0x00.
- Assert `reset` in the 3rd BUSY cycle of MUL → target register unchanged, no `result_valid` pulse, `ready` = 1 in the first cycle after reset release.
